// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the barrel-shifter stimulus sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_e;

  // Defaults sized wide; users cast down to DATA_W.
  localparam logic [63:0] DEF_LFSR_SEED = 64'hA5;
  localparam logic [63:0] DEF_LFSR_TAPS = 64'hB8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_vector_seq_if.sv
// Valid/ready vector bus between the sequencer (master) and the barrel shifter (slave).
interface shift_vector_seq_if #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = $clog2(DATA_W)
);
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [SHAMT_W-1:0] out_shamt;
  logic               out_dir;
  logic               out_last;

  modport master (output out_valid, out_data, out_shamt, out_dir, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_shamt, out_dir, out_last, output out_ready);
endinterface

// File: rtl/shift_seq_lfsr.sv
// Galois LFSR: load has priority over step; reset and load both return to SEED.
module shift_seq_lfsr #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   SEED = 8'hA5,
  parameter logic [W-1:0]   TAPS = 8'hB8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] q
);
  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = SEED;
    else if (step) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;
endmodule

// File: rtl/shift_vector_seq.sv
// Self-running stimulus source for the barrel shifter: LFSR operands, swept shamt/dir.
// Optional SHIFT_SEQ_SIGNATURE_EN adds a 16-bit rotate-xor signature of accepted vectors.
module shift_vector_seq
  import shift_seq_pkg::*;
#(
  parameter int                 DATA_W      = 8,
  parameter int                 SHAMT_W     = $clog2(DATA_W),
  parameter int                 NUM_VECTORS = 64,
  parameter logic [DATA_W-1:0]  LFSR_SEED   = DATA_W'(DEF_LFSR_SEED),
  parameter logic [DATA_W-1:0]  LFSR_TAPS   = DATA_W'(DEF_LFSR_TAPS)
) (
  input  logic                 sys_clock,
  input  logic                 reset_rtl,
  input  logic                 start,
  shift_vector_seq_if.master   ob,
`ifdef SHIFT_SEQ_SIGNATURE_EN
  output logic [15:0]          sig,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count
);
  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d, cnt_q, cnt_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic        xfer, is_last;
  logic [DATA_W-1:0] lfsr;

  assign xfer    = valid_q & ob.out_ready;
  assign is_last = (idx_q == 16'(NUM_VECTORS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: if (xfer) begin
        idx_d = idx_q + 16'd1;
        cnt_d = cnt_q + 16'd1;
        if (is_last) state_d = DONE;
      end
      DONE:  if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    // Status flags follow the next state so they are registered, not decoded.
    valid_d = (state_d == ISSUE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge sys_clock or posedge reset_rtl) begin
    if (reset_rtl) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  shift_seq_lfsr #(.W(DATA_W), .SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk  (sys_clock),
    .rst  (reset_rtl),
    .load (state_q == LOAD),
    .step (xfer),
    .q    (lfsr)
  );

`ifdef SHIFT_SEQ_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == LOAD) sig_d = '0;
    else if (xfer)       sig_d = {sig_q[14:0], sig_q[15]} ^ 16'({ob.out_dir, ob.out_shamt, ob.out_data});
  end

  always_ff @(posedge sys_clock or posedge reset_rtl) begin
    if (reset_rtl) sig_q <= '0;
    else           sig_q <= sig_d;
  end

  assign sig = sig_q;
`endif

  // Fields decode straight from idx so they cannot move while stalled.
  assign ob.out_valid = valid_q;
  assign ob.out_data  = lfsr;
  assign ob.out_shamt = idx_q[SHAMT_W-1:0];
  assign ob.out_dir   = idx_q[SHAMT_W];
  assign ob.out_last  = valid_q & is_last;
  assign busy         = valid_q;
  assign done         = done_q;
  assign vec_count    = cnt_q;
endmodule

// File: tb/tb_shift_vector_seq.sv
// Randomized-backpressure bench for shift_vector_seq against a queue-free arithmetic model.
module tb_shift_vector_seq;
  import shift_seq_pkg::*;

  localparam int         DW   = 8;
  localparam int         NV   = 64;
  localparam logic [7:0] SEED = 8'hA5;
  localparam logic [7:0] TAPS = 8'hB8;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
  logic        busy, done, busy1, done1;
  logic [15:0] vcnt, vcnt1;
`ifdef SHIFT_SEQ_SIGNATURE_EN
  logic [15:0] sig, sig1, last_sig;
`endif

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  shift_vector_seq_if #(.DATA_W(DW)) bus ();
  shift_vector_seq_if #(.DATA_W(DW)) bus1 ();

  shift_vector_seq #(.DATA_W(DW), .NUM_VECTORS(NV), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS)) dut (
    .sys_clock (clk),
    .reset_rtl (rst),
    .start     (start),
    .ob        (bus.master),
`ifdef SHIFT_SEQ_SIGNATURE_EN
    .sig       (sig),
`endif
    .busy      (busy),
    .done      (done),
    .vec_count (vcnt)
  );

  shift_vector_seq #(.DATA_W(DW), .NUM_VECTORS(1), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS)) dut_one (
    .sys_clock (clk),
    .reset_rtl (rst),
    .start     (start1),
    .ob        (bus1.master),
`ifdef SHIFT_SEQ_SIGNATURE_EN
    .sig       (sig1),
`endif
    .busy      (busy1),
    .done      (done1),
    .vec_count (vcnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run; abort_at>0 resets after that many transfers, bp forces a 5-cycle stall, poke
  // fires a stray start during ISSUE.
  task automatic do_run(input int abort_at, input bit bp, input bit poke);
    int          k = 0, cyc = 0, stall = 0, l = int'(SEED);
    logic        stalled = 1'b0;
    logic [12:0] cur, prev = '0;
`ifdef SHIFT_SEQ_SIGNATURE_EN
    logic [15:0] sm = '0;
`endif
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("lat_load", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_issue", 64'(bus.out_valid), 64'd1);
    while (k < NV && cyc < 4000) begin
      cur = {bus.out_last, bus.out_dir, bus.out_shamt, bus.out_data};
      if (stalled) chk("stable", 64'(cur), 64'(prev));
      chk("valid", 64'(bus.out_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("vcnt", 64'(vcnt), 64'(k));
      if (bp && k == 20 && stall < 5) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      start = poke && (cyc == 7);
      if (bus.out_ready) begin
        chk("data",  64'(bus.out_data),  64'(l));
        chk("shamt", 64'(bus.out_shamt), 64'(k % DW));
        chk("dir",   64'(bus.out_dir),   64'((k / DW) % 2));
        chk("last",  64'(bus.out_last),  64'(k == NV - 1));
        if (k == 0) chk("first_data", 64'(bus.out_data), 64'hA5);
        if (k == 1) chk("second_data", 64'(bus.out_data), 64'hEA);
        if (k == 8) chk("ninth_dir_shamt", 64'({bus.out_dir, bus.out_shamt}), 64'h8);
`ifdef SHIFT_SEQ_SIGNATURE_EN
        sm = {sm[14:0], sm[15]} ^ 16'((((k / DW) % 2) << 11) | ((k % DW) << 8) | l);
`endif
        l = (l / 2) ^ ((l % 2 == 1) ? int'(TAPS) : 0);
        k++;
      end
      stalled = !bus.out_ready;
      prev    = cur;
      @(negedge clk);
      cyc++;
      if (abort_at != 0 && k == abort_at) break;
    end
    bus.out_ready = 1'b0;
    start         = 1'b0;
    if (abort_at != 0) begin
      rst = 1'b1;
      #1;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_vcnt",  64'(vcnt), 64'd0);
      chk("rst_data",  64'(bus.out_data), 64'hA5);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      chk("timeout",   64'(cyc < 4000), 64'd1);
      chk("end_valid", 64'(bus.out_valid), 64'd0);
      chk("end_done",  64'(done), 64'd1);
      chk("end_busy",  64'(busy), 64'd0);
      chk("end_vcnt",  64'(vcnt), 64'(NV));
`ifdef SHIFT_SEQ_SIGNATURE_EN
      chk("sig",    64'(sig), 64'(sm));
      chk("sig_nz", 64'(sig != 16'd0), 64'd1);
      last_sig = sm;
`endif
    end
  endtask

  initial begin
    bus.out_ready  = 1'b0;
    bus1.out_ready = 1'b1;
    #20;
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_done",  64'(done), 64'd0);
    chk("reset_busy",  64'(busy), 64'd0);
    chk("reset_last",  64'(bus.out_last), 64'd0);
    chk("reset_vcnt",  64'(vcnt), 64'd0);
    chk("reset_shamt", 64'({bus.out_dir, bus.out_shamt}), 64'd0);
    chk("reset_data",  64'(bus.out_data), 64'hA5);
    @(negedge clk);
    rst = 1'b0;

    do_run(0, 1'b1, 1'b1);
`ifdef SHIFT_SEQ_SIGNATURE_EN
    begin
      logic [15:0] first_sig;
      first_sig = sig;
      do_run(0, 1'b0, 1'b0);
      chk("sig_repeat", 64'(sig), 64'(first_sig));
    end
`else
    do_run(0, 1'b0, 1'b0);
`endif
    do_run(10, 1'b0, 1'b0);
    chk("post_rst_done", 64'(done), 64'd0);
    do_run(0, 1'b1, 1'b0);

    // Single-vector run: first vector is also the last.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    chk("one_valid", 64'(bus1.out_valid), 64'd1);
    chk("one_last",  64'(bus1.out_last), 64'd1);
    chk("one_data",  64'(bus1.out_data), 64'hA5);
    @(negedge clk);
    chk("one_done",  64'(done1), 64'd1);
    chk("one_idle",  64'(bus1.out_valid), 64'd0);
    chk("one_vcnt",  64'(vcnt1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
